// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: serves 8227 CPU bus cycles from a req/ack memory port.
// Writes are posted through a small FIFO; reads stall the CPU until data returns.
module cpu_bus_responder #(
  parameter int ADDR_W     = 16,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic                          cpu_rnw,
  input  logic [7:0]                    cpu_wdata,
  input  logic                          cpu_strobe,
  output logic                          cpu_ready,
  output logic [7:0]                    cpu_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [7:0]                    mem_wdata,
  input  logic                          mem_ack,
  input  logic [7:0]                    mem_rdata,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
  output logic                          wr_overflow
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(WBUF_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_fa [WBUF_DEPTH];
  logic [7:0]        r_fd [WBUF_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_count;
  logic              r_ovf;
  logic              r_rd_valid;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [7:0]        r_rdata;

  logic w_wr_req;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_pending;
  logic w_issue_rd;
  logic w_rd_done;

  assign cpu_ready = r_rd_valid & cpu_rnw & (r_rd_addr == cpu_addr);
  assign w_pending = cpu_rnw & ~cpu_ready;
  assign w_wr_req  = cpu_strobe & ~cpu_rnw;
  assign w_full    = (r_count == CNT_FULL);
  assign w_pop     = (r_state == S_WRITE) & mem_ack;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push    = w_wr_req & (~w_full | w_pop);

  assign cpu_rdata   = r_rdata;
  assign wbuf_count  = r_count;
  assign wr_overflow = r_ovf;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and memory port drive; posted writes win over reads.
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    w_issue_rd = 1'b0;
    w_rd_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_next = S_WRITE;
        end else if (w_pending) begin
          w_next     = S_READ;
          w_issue_rd = 1'b1;
        end
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_fa[r_rptr];
        mem_wdata = r_fd[r_rptr];
        if (mem_ack) w_next = S_IDLE;
      end
      S_READ: begin
        mem_req  = 1'b1;
        mem_addr = r_rd_addr;
        if (mem_ack) begin
          w_next    = S_IDLE;
          w_rd_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Posted-write storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fa[r_wptr] <= cpu_addr;
      r_fd[r_wptr] <= cpu_wdata;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_wr_req & ~w_push) r_ovf <= 1'b1;
    end
  end

  // Read tracking; issuing a read invalidates old data so it is never acked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_rdata    <= '0;
    end else if (w_issue_rd) begin
      r_rd_valid <= 1'b0;
      r_rd_addr  <= cpu_addr;
    end else if (w_rd_done) begin
      r_rd_valid <= 1'b1;
      r_rdata    <= mem_rdata;
    end else if (cpu_strobe & cpu_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed scenarios plus random CPU/memory traffic,
// checked against a queue-based model of the posted-write/read behaviour.
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rnw;
  logic [7:0]  cpu_wdata;
  logic        cpu_strobe;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [2:0]  wbuf_count;
  logic        wr_overflow;

  always #5 clk = ~clk;

  cpu_bus_responder #(.ADDR_W(16), .WBUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_wdata(cpu_wdata),
    .cpu_strobe(cpu_strobe), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wbuf_count(wbuf_count), .wr_overflow(wr_overflow)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
  } txn_t;

  int   checks = 0;
  int   errors = 0;
  txn_t wq[$];
  txn_t log_q[$];
  bit   m_ovf, m_valid, m_reading, prev_ack, auto_mem;
  logic [15:0] m_vaddr = '0;
  logic [15:0] m_raddr = '0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  m_data = '0;
  int   lat = 0;
  bit   in_read;
  int   rd_wait;

  function automatic logic [7:0] fdat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory side: random 0..3 clk latency, read data derived from address.
  task automatic responder();
    if (!auto_mem) return;
    mem_ack = 1'b0;
    if (!mem_req) begin
      lat = $urandom_range(0, 3);
    end else if (lat == 0) begin
      mem_ack   = 1'b1;
      mem_rdata = fdat(mem_addr);
    end else begin
      lat--;
    end
  endtask

  // Check this cycle against the model, advance the model, cross one edge.
  task automatic step();
    bit exp_ready;
    bit popped;
    bit rdone;
    #1;
    if (mem_req && !mem_we) begin
      if (!m_reading) begin
        chk("rd_issue_fifo_empty", wq.size(), 0);
        chk("rd_issue_addr", mem_addr, prev_addr);
        m_reading = 1'b1;
        m_raddr   = prev_addr;
        m_valid   = 1'b0;
      end else begin
        chk("rd_addr_stable", mem_addr, m_raddr);
      end
    end
    if (mem_req && mem_we) begin
      if (wq.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        chk("wr_addr", mem_addr, wq[0].a);
        chk("wr_data", mem_wdata, wq[0].d);
      end
    end
    if (prev_ack) chk("idle_gap", mem_req, 0);
    exp_ready = m_valid && cpu_rnw && (m_vaddr == cpu_addr);
    chk("cpu_ready", cpu_ready, exp_ready);
    if (exp_ready) chk("cpu_rdata", cpu_rdata, m_data);
    chk("wbuf_count", wbuf_count, wq.size());
    chk("wr_overflow", wr_overflow, m_ovf);
    popped = mem_ack && mem_req && mem_we;
    rdone  = mem_ack && mem_req && !mem_we;
    if (mem_ack && mem_req)
      log_q.push_back(txn_t'{mem_we, mem_addr,
                             (mem_we ? mem_wdata : mem_rdata)});
    if (rst) begin
      wq.delete();
      m_ovf     = 1'b0;
      m_valid   = 1'b0;
      m_reading = 1'b0;
      prev_ack  = 1'b0;
    end else begin
      if (popped) void'(wq.pop_front());
      if (cpu_strobe && !cpu_rnw) begin
        if (wq.size() < 4) wq.push_back(txn_t'{1'b1, cpu_addr, cpu_wdata});
        else m_ovf = 1'b1;
      end
      if (cpu_strobe && exp_ready) m_valid = 1'b0;
      if (rdone) begin
        m_valid   = 1'b1;
        m_vaddr   = m_raddr;
        m_data    = mem_rdata;
        m_reading = 1'b0;
      end
      prev_ack = mem_ack && mem_req;
    end
    prev_addr = cpu_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    responder();
    step();
  endtask

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_rnw = 1'b0; cpu_wdata = '0;
    cpu_strobe = 1'b0; mem_ack = 1'b0; mem_rdata = '0; auto_mem = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_count", wbuf_count, 0);
    chk("rst_ovf", wr_overflow, 0);
    rst = 1'b0;

    // Read 0x1234, ack after 3 clk with 0xA5.
    cpu_addr = 16'h1234; cpu_rnw = 1'b1;
    step();
    chk("t1_req", mem_req, 1);
    chk("t1_we", mem_we, 0);
    chk("t1_addr", mem_addr, 16'h1234);
    step();
    step();
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    step();
    mem_ack = 1'b0;
    chk("t1_ready", cpu_ready, 1);
    chk("t1_rdata", cpu_rdata, 8'hA5);
    chk("t1_req_gap", mem_req, 0);
    cpu_strobe = 1'b1;
    step();
    cpu_strobe = 1'b0;
    chk("t1_consumed", cpu_ready, 0);
    cpu_rnw = 1'b0;

    // Two posted writes then a read of the first address.
    log_q.delete(); auto_mem = 1'b1;
    cpu_addr = 16'h0200; cpu_wdata = 8'h11; cpu_strobe = 1'b1;
    cyc();
    cpu_addr = 16'h0201; cpu_wdata = 8'h22;
    cyc();
    cpu_strobe = 1'b0; cpu_rnw = 1'b1; cpu_addr = 16'h0200;
    for (int i = 0; i < 60 && !cpu_ready; i++) cyc();
    chk("t2_ready", cpu_ready, 1);
    chk("t2_ntx", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      chk("t2_tx0", log_q[0], txn_t'{1'b1, 16'h0200, 8'h11});
      chk("t2_tx1", log_q[1], txn_t'{1'b1, 16'h0201, 8'h22});
      chk("t2_tx2", log_q[2], txn_t'{1'b0, 16'h0200, fdat(16'h0200)});
    end
    cpu_strobe = 1'b1;
    cyc();
    cpu_strobe = 1'b0; cpu_rnw = 1'b0;

    // Five writes with memory stalled: one dropped.
    auto_mem = 1'b0; mem_ack = 1'b0; log_q.delete();
    for (int i = 0; i < 5; i++) begin
      cpu_addr = 16'h0300 + 16'(i); cpu_wdata = 8'h30 + 8'(i);
      cpu_strobe = 1'b1;
      step();
    end
    cpu_strobe = 1'b0;
    chk("t3_count", wbuf_count, 4);
    chk("t3_ovf", wr_overflow, 1);
    auto_mem = 1'b1;
    for (int i = 0; i < 60 && wbuf_count != 0; i++) cyc();
    chk("t3_ntx", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk("t3_order", log_q[i],
          txn_t'{1'b1, 16'h0300 + 16'(i), 8'h30 + 8'(i)});

    // Address change while a read is in flight.
    auto_mem = 1'b0; mem_ack = 1'b0; log_q.delete();
    cyc();
    cpu_rnw = 1'b1; cpu_addr = 16'h00FF;
    step();
    chk("t4_req", mem_req, 1);
    chk("t4_addr", mem_addr, 16'h00FF);
    cpu_addr = 16'h0100; auto_mem = 1'b1;
    for (int i = 0; i < 60 && !cpu_ready; i++) cyc();
    chk("t4_ready", cpu_ready, 1);
    chk("t4_rdata", cpu_rdata, fdat(16'h0100));
    chk("t4_ntx", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("t4_tx0", log_q[0], txn_t'{1'b0, 16'h00FF, fdat(16'h00FF)});
      chk("t4_tx1", log_q[1], txn_t'{1'b0, 16'h0100, fdat(16'h0100)});
    end
    cpu_strobe = 1'b1;
    cyc();
    cpu_strobe = 1'b0; cpu_rnw = 1'b0;

    // Reset during a write transaction, then a stray ack.
    auto_mem = 1'b0; mem_ack = 1'b0;
    cpu_addr = 16'h0400; cpu_wdata = 8'h44; cpu_strobe = 1'b1;
    step();
    cpu_strobe = 1'b0;
    step();
    chk("t5_req_before", mem_req, 1);
    chk("t5_we_before", mem_we, 1);
    rst = 1'b1;
    step();
    chk("t5_req_rst", mem_req, 0);
    chk("t5_count_rst", wbuf_count, 0);
    chk("t5_ovf_rst", wr_overflow, 0);
    rst = 1'b0; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t5_stray_req", mem_req, 0);
    chk("t5_stray_count", wbuf_count, 0);
    step();
    chk("t5_stray_req2", mem_req, 0);

    // Write into a full FIFO on the same clk as a pop.
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 16'h0500 + 16'(i); cpu_wdata = 8'h50 + 8'(i);
      cpu_strobe = 1'b1;
      step();
    end
    chk("t6_full", wbuf_count, 4);
    cpu_addr = 16'h0504; cpu_wdata = 8'h54; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; cpu_strobe = 1'b0;
    chk("t6_count", wbuf_count, 4);
    chk("t6_ovf", wr_overflow, 0);
    auto_mem = 1'b1;
    for (int i = 0; i < 80 && wbuf_count != 0; i++) cyc();
    chk("t6_ntx", log_q.size(), 5);
    for (int i = 0; i < 5 && i < log_q.size(); i++)
      chk("t6_order", log_q[i],
          txn_t'{1'b1, 16'h0500 + 16'(i), 8'h50 + 8'(i)});

    // Random CPU traffic against a random-latency memory.
    in_read = 1'b0; rd_wait = 0;
    for (int n = 0; n < 3000; n++) begin
      cpu_strobe = 1'b0;
      if (in_read) begin
        if (cpu_ready) begin
          cpu_strobe = 1'b1;
          in_read = 1'b0;
        end else begin
          rd_wait++;
          if ($urandom_range(0, 19) == 0)
            cpu_addr = 16'h0200 | 16'($urandom_range(0, 7));
        end
        if (rd_wait > 200) begin
          chk("rand_rd_timeout", rd_wait, 0);
          in_read = 1'b0;
          rd_wait = 0;
        end
      end else if ($urandom_range(0, 9) < 4) begin
        cpu_rnw = 1'b0;
        cpu_addr = 16'h0200 | 16'($urandom_range(0, 7));
        cpu_wdata = 8'($urandom);
        cpu_strobe = 1'b1;
      end else begin
        cpu_rnw = 1'b1;
        cpu_addr = 16'h0200 | 16'($urandom_range(0, 7));
        in_read = 1'b1;
        rd_wait = 0;
      end
      cyc();
    end
    cpu_strobe = 1'b0; cpu_rnw = 1'b0;
    for (int i = 0; i < 100 && (wbuf_count != 0 || mem_req); i++) cyc();
    chk("final_drained", {wbuf_count, mem_req}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
